// File: rtl/seq_detector.sv
// Streaming pattern detector: matches a PAT_LEN-symbol pattern against accepted input symbols,
// reports prefix progress, counts matches with a saturating counter and a sticky overflow flag.
module seq_detector #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MOORE   = 0,
  parameter int unsigned OVERLAP = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         clear_i,
  input  logic                         load_i,
  input  logic [PAT_LEN*SYM_W-1:0]     pattern_i,
  input  logic                         valid_i,
  input  logic [SYM_W-1:0]             data_i,
  output logic                         match_o,
  output logic [$clog2(PAT_LEN+1)-1:0] progress_o,
  output logic [CNT_W-1:0]             count_o,
  output logic                         overflow_o
);

  localparam int unsigned PW = $clog2(PAT_LEN + 1);
  localparam int unsigned HW = (PAT_LEN - 1) * SYM_W;
  localparam logic [PW-1:0] FillMax = PW'(PAT_LEN - 1);

  logic [PAT_LEN*SYM_W-1:0] pat_q, pat_d;
  logic [HW-1:0]            hist_q, hist_d, hist_shift;
  logic [PW-1:0]            fill_q, fill_d, fill_inc;
  logic [PW-1:0]            prog_q, prog_d, prog_shift;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     match_q, match_d;
  logic                     accept, hit, prefix_ok;

  assign accept = valid_i & ~clear_i & ~load_i;

  // Oldest held symbol sits at slot 0 and must equal pattern symbol 0.
  always_comb begin
    hit = (fill_q == FillMax) && (data_i == pat_q[(PAT_LEN-1)*SYM_W +: SYM_W]);
    for (int i = 0; i < PAT_LEN - 1; i++) begin
      if (hist_q[i*SYM_W +: SYM_W] != pat_q[i*SYM_W +: SYM_W]) begin
        hit = 1'b0;
      end
    end
  end

  // History and progress as they would be after accepting data_i.
  always_comb begin
    hist_shift = hist_q >> SYM_W;
    hist_shift[(PAT_LEN-2)*SYM_W +: SYM_W] = data_i;
    fill_inc   = (fill_q == FillMax) ? fill_q : fill_q + PW'(1);
    prog_shift = '0;
    prefix_ok  = 1'b0;
    for (int k = 1; k < PAT_LEN; k++) begin
      prefix_ok = (fill_inc >= PW'(k));
      for (int j = 0; j < k; j++) begin
        if (hist_shift[(PAT_LEN-1-k+j)*SYM_W +: SYM_W] != pat_q[j*SYM_W +: SYM_W]) begin
          prefix_ok = 1'b0;
        end
      end
      if (prefix_ok) begin
        prog_shift = PW'(k);
      end
    end
  end

  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    prog_d  = prog_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    match_d = 1'b0;
    if (clear_i) begin
      hist_d  = '0;
      fill_d  = '0;
      prog_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      pat_d  = pattern_i;
      hist_d = '0;
      fill_d = '0;
      prog_d = '0;
    end else if (valid_i) begin
      match_d = hit;
      if (hit) begin
        if (&count_q) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      if (hit && (OVERLAP == 0)) begin
        hist_d = '0;
        fill_d = '0;
        prog_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = fill_inc;
        prog_d = prog_shift;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      prog_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      prog_q  <= prog_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  assign match_o    = (MOORE != 0) ? match_q : (accept & hit & reset_ni);
  assign progress_o = prog_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter SYM_W, default 2, width in bits of one input symbol (1..8).
REQ-002 Parameter PAT_LEN, default 4, pattern length in symbols (2..8).
REQ-003 Parameter CNT_W, default 8, match-counter width in bits.
REQ-004 Parameter MOORE, default 0; 0 selects Mealy (combinational) match output, 1 selects Moore (registered) match output.
REQ-005 Parameter OVERLAP, default 1; 1 allows overlapping matches, 0 restarts detection after each match.
REQ-006 clk_i  input  1  clock; all state updates on rising edge.
REQ-007 reset_ni  input  1  reset, asynchronous, active-low.
REQ-008 clear_i  input  1  synchronous clear of history, progress, counter and overflow.
REQ-009 load_i  input  1  synchronous pattern load strobe.
REQ-010 pattern_i  input  PAT_LEN*SYM_W  pattern; symbol k (k-th to arrive, k from 0) at bits [k*SYM_W +: SYM_W].
REQ-011 valid_i  input  1  data_i carries a symbol this cycle.
REQ-012 data_i  input  SYM_W  input symbol.
REQ-013 match_o  output  1  pattern-complete pulse.
REQ-014 progress_o  output  $clog2(PAT_LEN+1)  current matched-prefix length (FSM state).
REQ-015 count_o  output  CNT_W  number of matches since reset/clear.
REQ-016 overflow_o  output  1  sticky counter-saturation flag.

Function
REQ-017 Priority per cycle SHALL be clear_i > load_i > valid_i; a lower-priority event in the same cycle SHALL be ignored.
REQ-018 A symbol SHALL be accepted only in cycles with valid_i=1 and clear_i=0 and load_i=0; cycles with valid_i=0 SHALL leave all state unchanged (bubbles do not break a sequence).
REQ-019 load_i SHALL capture pattern_i into the pattern register and zero history and progress_o; count_o and overflow_o SHALL be kept.
REQ-020 The block SHALL hold the last PAT_LEN-1 accepted symbols and a fill count saturating at PAT_LEN-1.
REQ-021 An accepted symbol SHALL complete a match when fill = PAT_LEN-1, the held symbols equal pattern symbols 0..PAT_LEN-2 in arrival order, and data_i equals pattern symbol PAT_LEN-1.
REQ-022 MOORE=0: match_o SHALL be high combinationally in the accepting cycle of a completing symbol, low otherwise.
REQ-023 MOORE=1: match_o SHALL be registered, high for exactly the one cycle after the completing symbol's accepting cycle.
REQ-024 progress_o SHALL be registered and equal the largest k in 0..PAT_LEN-1, k <= fill, such that the last k accepted symbols equal pattern symbols 0..k-1.
REQ-025 OVERLAP=1: after a match the history SHALL be retained, so progress_o becomes the longest proper pattern prefix that is a suffix of the match.
REQ-026 OVERLAP=0: a match SHALL zero fill, history and progress_o in that same edge.
REQ-027 Each match SHALL increment count_o by 1; at all-ones count_o SHALL hold and overflow_o SHALL set and stay set until clear_i or reset.
REQ-028 clear_i SHALL zero history, fill, progress_o, count_o, overflow_o and registered match_o; the pattern register SHALL be kept.
REQ-029 Mealy match_o SHALL be low in any cycle with clear_i=1 or load_i=1.

Reset
REQ-030 reset_ni low SHALL immediately force pattern register to 0, history and fill to 0, progress_o=0, count_o=0, overflow_o=0, registered match_o=0; Mealy match_o SHALL be low while reset_ni is low.
REQ-031 Reset asserted mid-sequence SHALL discard partial progress; detection SHALL restart from the first accepted symbol after release.

Verification
REQ-032 Defaults, load pattern_i=8'hEE (symbols 2,3,2,3), stream 2,3,2,3,2,3,2,3 back-to-back -> match_o high on symbols 4, 6, 8; count_o=3; progress_o=2 after each match.
REQ-033 Same stream with OVERLAP=0 -> matches on symbols 4 and 8 only; count_o=2; progress_o=0 after each match.
REQ-034 Pattern 8'hEE, stream 2,3,2 with valid_i low 3 cycles, then 3 -> one match; progress_o=3 held through bubbles.
REQ-035 MOORE=1, pattern 8'hEE, stream 2,3,2,3 -> match_o high one cycle after symbol 4 accepted, exactly one cycle wide.
REQ-036 CNT_W=2, overlap, pattern 8'hEE, stream producing 5 matches -> count_o=3, overflow_o=1; clear_i -> both 0, pattern kept.
REQ-037 Stream 2,3,2, reset_ni pulsed low, then 3,2,3,2,3 -> no match until symbol 5 after reset (progress_o 0 immediately on reset, pattern 0 so reload required: reload 8'hEE after reset, then 2,3,2,3 -> match on 4th).
